// File: rtl/vga_scan_out.sv
//-----------------------------------------------------------------------------
// vga_scan_out
//
// Raster timing generator and scan-out stage for the frame-image ROM path.
// Owns the 800x600 raster, issues a row-major read address to the frame ROM,
// takes back the 12-bit {r,g,b} word RD_LAT cycles later, and drives the
// VGA connector with blanking applied.
//
// Every output leaves the block RD_LAT+1 cycles after the raster position it
// belongs to. rd_addr is the one exception: it is the stage-0 request itself.
//
// Optional build macro: VGA_TEST_PATTERN_EN
//   When defined, the block gains a pat_en input. With pat_en=1 the visible
//   pixels show eight vertical colour bars instead of rgb_in. Timing,
//   rd_addr and de do not change.
//
// Ports:
//   clk          in   1   pixel clock
//   rst          in   1   synchronous active-high reset
//   pat_en       in   1   colour-bar select (VGA_TEST_PATTERN_EN builds only)
//   rd_addr      out  19  frame ROM address, 0..H_ACTIVE*V_ACTIVE-1
//   rgb_in       in   12  ROM data {r,g,b}, valid RD_LAT cycles after rd_addr
//   r, g, b      out  4   colour channels, 0 while blanked
//   hs, vs       out  1   sync pulses, asserted level = SYNC_POL
//   de           out  1   display enable, aligned with r/g/b
//   frame_start  out  1   one-cycle pulse with pixel (0,0) on the outputs
//-----------------------------------------------------------------------------
module vga_scan_out #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        pat_en,
`endif
  output logic [18:0] rd_addr,
  input  logic [11:0] rgb_in,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST_C   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ALAST_C  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SSTART_C = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SEND_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST_C   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ALAST_C  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SSTART_C = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SEND_C   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Stage-0 raster state
  logic [HW-1:0] h_cnt_r, h_nxt_s;
  logic [VW-1:0] v_cnt_r, v_nxt_s;
  logic [18:0]   addr_r, addr_nxt_s;
  logic          h_wrap_s, v_wrap_s, last_px_s;
  logic          active_s, hs_raw_s, vs_raw_s, fs_raw_s;

  // Delay lines matching the ROM latency; index RD_LAT-1 is the aligned tap
  logic [RD_LAT-1:0] act_sr_r;
  logic [RD_LAT-1:0] hs_sr_r;
  logic [RD_LAT-1:0] vs_sr_r;
  logic [RD_LAT-1:0] fs_sr_r;

  logic [11:0] pix_s;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W + 1);
  localparam logic [BW-1:0] BAR_LAST_C = BW'(BAR_W - 1);

  logic [BW-1:0] bar_px_r;
  logic [2:0]    bar_idx_r;
  logic [2:0]    bar_sr_r [RD_LAT];

  // Bar colours, left to right: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      3'd7:    c = 12'h000;
      default: c = 12'h000;
    endcase
    return c;
  endfunction
`endif

  // Raster decode: counter next-state, address next-state and stage-0 flags
  always_comb begin
    h_wrap_s  = (h_cnt_r == H_LAST_C);
    v_wrap_s  = (v_cnt_r == V_LAST_C);
    active_s  = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
    hs_raw_s  = (h_cnt_r >= H_SSTART_C) && (h_cnt_r < H_SEND_C);
    // vs depends on v_cnt only, so it can only move on a line boundary
    vs_raw_s  = (v_cnt_r >= V_SSTART_C) && (v_cnt_r < V_SEND_C);
    fs_raw_s  = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
    last_px_s = (h_cnt_r == H_ALAST_C) && (v_cnt_r == V_ALAST_C);

    if (h_wrap_s) begin
      h_nxt_s = {HW{1'b0}};
    end else begin
      h_nxt_s = h_cnt_r + HW'(1);
    end

    if (h_wrap_s && v_wrap_s) begin
      v_nxt_s = {VW{1'b0}};
    end else if (h_wrap_s) begin
      v_nxt_s = v_cnt_r + VW'(1);
    end else begin
      v_nxt_s = v_cnt_r;
    end

    // The final visible pixel does not advance the address, so the
    // one-past-the-end value is never put on the bus during vertical blanking.
    if (h_wrap_s && v_wrap_s) begin
      addr_nxt_s = 19'd0;
    end else if (active_s && !last_px_s) begin
      addr_nxt_s = addr_r + 19'd1;
    end else begin
      addr_nxt_s = addr_r;
    end
  end

  // Raster counters and ROM read address
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_r <= {HW{1'b0}};
      v_cnt_r <= {VW{1'b0}};
      addr_r  <= 19'd0;
    end else begin
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
      addr_r  <= addr_nxt_s;
    end
  end

  assign rd_addr = addr_r;

  // Control delay lines, RD_LAT deep, so flags meet the matching ROM word
  always_ff @(posedge clk) begin
    if (rst) begin
      act_sr_r <= {RD_LAT{1'b0}};
      hs_sr_r  <= {RD_LAT{1'b0}};
      vs_sr_r  <= {RD_LAT{1'b0}};
      fs_sr_r  <= {RD_LAT{1'b0}};
    end else begin
      act_sr_r[0] <= active_s;
      hs_sr_r[0]  <= hs_raw_s;
      vs_sr_r[0]  <= vs_raw_s;
      fs_sr_r[0]  <= fs_raw_s;
      for (int i = 1; i < RD_LAT; i++) begin
        act_sr_r[i] <= act_sr_r[i-1];
        hs_sr_r[i]  <= hs_sr_r[i-1];
        vs_sr_r[i]  <= vs_sr_r[i-1];
        fs_sr_r[i]  <= fs_sr_r[i-1];
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Stage-0 bar position: a pixel counter within the bar plus the bar number
  always_ff @(posedge clk) begin
    if (rst) begin
      bar_px_r  <= {BW{1'b0}};
      bar_idx_r <= 3'd0;
    end else if (h_wrap_s) begin
      bar_px_r  <= {BW{1'b0}};
      bar_idx_r <= 3'd0;
    end else if (active_s) begin
      if (bar_px_r == BAR_LAST_C) begin
        bar_px_r  <= {BW{1'b0}};
        bar_idx_r <= bar_idx_r + 3'd1;
      end else begin
        bar_px_r  <= bar_px_r + BW'(1);
        bar_idx_r <= bar_idx_r;
      end
    end else begin
      bar_px_r  <= bar_px_r;
      bar_idx_r <= bar_idx_r;
    end
  end

  // Delay the bar number alongside the other control flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        bar_sr_r[i] <= 3'd0;
      end
    end else begin
      bar_sr_r[0] <= bar_idx_r;
      for (int i = 1; i < RD_LAT; i++) begin
        bar_sr_r[i] <= bar_sr_r[i-1];
      end
    end
  end
`endif

  // Pixel source select with blanking; rgb_in is ignored outside the active area
  always_comb begin
    pix_s = 12'h000;
    if (act_sr_r[RD_LAT-1]) begin
`ifdef VGA_TEST_PATTERN_EN
      if (pat_en) begin
        pix_s = bar_colour(bar_sr_r[RD_LAT-1]);
      end else begin
        pix_s = rgb_in;
      end
`else
      pix_s = rgb_in;
`endif
    end else begin
      pix_s = 12'h000;
    end
  end

  // Output register; sync polarity applied here so the raw flags stay active-high
  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= 4'h0;
      g           <= 4'h0;
      b           <= 4'h0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
    end else begin
      r           <= pix_s[11:8];
      g           <= pix_s[7:4];
      b           <= pix_s[3:0];
      de          <= act_sr_r[RD_LAT-1];
      frame_start <= fs_sr_r[RD_LAT-1];
      hs          <= ~(hs_sr_r[RD_LAT-1] ^ SYNC_POL);
      vs          <= ~(vs_sr_r[RD_LAT-1] ^ SYNC_POL);
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
`timescale 1ns/1ps
module tb_vga_scan_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: full 800x600 timing, RD_LAT=1, positive sync
  logic        rst_a;
  logic [18:0] rd_addr_a;
  logic [11:0] rgb_in_a;
  logic [3:0]  r_a, g_a, b_a;
  logic        hs_a, vs_a, de_a, fs_a;
  // dut_b: shrunken raster (24x14 total, 16x8 visible), RD_LAT=2, negative sync
  logic        rst_b;
  logic [18:0] rd_addr_b;
  logic [11:0] rgb_in_b;
  logic [3:0]  r_b, g_b, b_b;
  logic        hs_b, vs_b, de_b, fs_b;
`ifdef VGA_TEST_PATTERN_EN
  logic        pat_en_a, pat_en_b;
`endif

  vga_scan_out dut_a (
    .clk(clk), .rst(rst_a),
`ifdef VGA_TEST_PATTERN_EN
    .pat_en(pat_en_a),
`endif
    .rd_addr(rd_addr_a), .rgb_in(rgb_in_a),
    .r(r_a), .g(g_a), .b(b_a), .hs(hs_a), .vs(vs_a), .de(de_a), .frame_start(fs_a)
  );

  vga_scan_out #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .RD_LAT(2)
  ) dut_b (
    .clk(clk), .rst(rst_b),
`ifdef VGA_TEST_PATTERN_EN
    .pat_en(pat_en_b),
`endif
    .rd_addr(rd_addr_b), .rgb_in(rgb_in_b),
    .r(r_b), .g(g_b), .b(b_b), .hs(hs_b), .vs(vs_b), .de(de_b), .frame_start(fs_b)
  );

  // ROM models: data = address[11:0], delivered after the configured latency
  logic [11:0] rom_a_q;
  logic [11:0] rom_b_q1, rom_b_q2;
  always_ff @(posedge clk) begin
    rom_a_q  <= rd_addr_a[11:0];
    rom_b_q1 <= rd_addr_b[11:0];
    rom_b_q2 <= rom_b_q1;
  end
  assign rgb_in_a = rom_a_q;
  assign rgb_in_b = rom_b_q2;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          cyc;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] rgb;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input int cyc, input logic de, input logic hs, input logic vs,
                         input logic fs, input logic [11:0] rgb, input string name);
    vec_t v;
    v.cyc = cyc; v.de = de; v.hs = hs; v.vs = vs; v.fs = fs; v.rgb = rgb; v.name = name;
    vq.push_back(v);
  endtask

  // measurement state
  logic        de_prev, hs_prev, vs_prev;
  logic [18:0] addr_prev;
  int de_rise1, de_rise2, de_fall1, hs_rise1, hs_fall1, vs_rise1, vs_fall1;
  int fs_cnt, fs_cyc1, fs_cyc2, de_cnt, blank_rgb_bad, addr_max, wrap_val;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    pat_en_a = 1'b0;
    pat_en_b = 1'b0;
`endif

    // Expected outputs of dut_a; cycle n after release shows raster step n-2
    add_vec(1,    1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "pre_first");
    add_vec(2,    1'b1, 1'b0, 1'b0, 1'b1, 12'h000, "px_0_0");
    add_vec(3,    1'b1, 1'b0, 1'b0, 1'b0, 12'h001, "px_1_0");
    add_vec(801,  1'b1, 1'b0, 1'b0, 1'b0, 12'h31F, "px_799_0");
    add_vec(802,  1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "blank_800_0");
    add_vec(857,  1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "hs_before");
    add_vec(858,  1'b0, 1'b1, 1'b0, 1'b0, 12'h000, "hs_first");
    add_vec(977,  1'b0, 1'b1, 1'b0, 1'b0, 12'h000, "hs_last");
    add_vec(978,  1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "hs_after");
    add_vec(1042, 1'b1, 1'b0, 1'b0, 1'b0, 12'h320, "px_0_1");
    add_vec(1900, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, "blank_858_1");
    add_vec(2082, 1'b1, 1'b0, 1'b0, 1'b0, 12'h640, "px_0_2");
    add_vec(2087, 1'b1, 1'b0, 1'b0, 1'b0, 12'h645, "px_5_2");

    // ---------------- dut_a: reset and line timing ----------------
    repeat (5) tick();
    check("a_rst_hs", hs_a, 1'b0);
    check("a_rst_vs", vs_a, 1'b0);
    check("a_rst_de", de_a, 1'b0);
    check("a_rst_fs", fs_a, 1'b0);
    check("a_rst_rgb", {r_a, g_a, b_a}, 12'h000);
    rst_a = 1'b0;
    check("a_addr_first", rd_addr_a, 19'd0);

    de_prev = 1'b0; hs_prev = 1'b0;
    de_rise1 = -1; de_rise2 = -1; de_fall1 = -1; hs_rise1 = -1; hs_fall1 = -1;
    fs_cnt = 0; blank_rgb_bad = 0;
    for (int n = 0; n <= 2100; n++) begin
      foreach (vq[k]) begin
        if (vq[k].cyc == n) begin
          check({"a_de_", vq[k].name}, de_a, vq[k].de);
          check({"a_hs_", vq[k].name}, hs_a, vq[k].hs);
          check({"a_vs_", vq[k].name}, vs_a, vq[k].vs);
          check({"a_fs_", vq[k].name}, fs_a, vq[k].fs);
          check({"a_rgb_", vq[k].name}, {r_a, g_a, b_a}, vq[k].rgb);
        end
      end
      if (n == 1)    check("a_addr_second", rd_addr_a, 19'd1);
      if (n == 1000) check("a_addr_hold_blank", rd_addr_a, 19'd800);
      if (de_a && !de_prev) begin
        if (de_rise1 < 0) de_rise1 = n;
        else if (de_rise2 < 0) de_rise2 = n;
      end
      if (!de_a && de_prev && de_fall1 < 0) de_fall1 = n;
      if (hs_a && !hs_prev && hs_rise1 < 0) hs_rise1 = n;
      if (!hs_a && hs_prev && hs_fall1 < 0) hs_fall1 = n;
      if (fs_a) fs_cnt++;
      if (!de_a && ({r_a, g_a, b_a} != 12'h000)) blank_rgb_bad++;
      de_prev = de_a; hs_prev = hs_a;
      tick();
    end
    check("a_de_first_rise", de_rise1, 2);
    check("a_de_run_len", de_fall1 - de_rise1, 800);
    check("a_line_period", de_rise2 - de_rise1, 1040);
    check("a_hs_after_de", hs_rise1 - de_fall1, 56);
    check("a_hs_width", hs_fall1 - hs_rise1, 120);
    check("a_fs_count", fs_cnt, 1);
    check("a_rgb_blank", blank_rgb_bad, 0);

    // ---------------- dut_b: frames, vsync, address wrap ----------------
    rst_a = 1'b1;
    tick();
    check("b_rst_hs", hs_b, 1'b1);
    check("b_rst_vs", vs_b, 1'b1);
    check("b_rst_de", de_b, 1'b0);
    rst_b = 1'b0;
    check("b_addr_first", rd_addr_b, 19'd0);

    de_prev = 1'b0; hs_prev = 1'b1; vs_prev = 1'b1; addr_prev = 19'd0;
    hs_rise1 = -1; hs_fall1 = -1; vs_rise1 = -1; vs_fall1 = -1;
    fs_cnt = 0; fs_cyc1 = -1; fs_cyc2 = -1; de_cnt = 0; blank_rgb_bad = 0;
    addr_max = 0; wrap_val = -1;
    for (int n = 0; n <= 600; n++) begin
      if (n == 56)  check("b_px_5_2_f1", {r_b, g_b, b_b}, 12'd37);
      if (n == 392) check("b_px_5_2_f2", {r_b, g_b, b_b}, 12'd37);
      if (fs_b) begin
        fs_cnt++;
        if (fs_cyc1 < 0) fs_cyc1 = n;
        else if (fs_cyc2 < 0) fs_cyc2 = n;
      end
      if (de_b) de_cnt++;
      if (!de_b && ({r_b, g_b, b_b} != 12'h000)) blank_rgb_bad++;
      if (!hs_b && hs_prev && hs_rise1 < 0) hs_rise1 = n;
      if (hs_b && !hs_prev && hs_fall1 < 0) hs_fall1 = n;
      if (!vs_b && vs_prev && vs_rise1 < 0) vs_rise1 = n;
      if (vs_b && !vs_prev && vs_fall1 < 0) vs_fall1 = n;
      if (int'(rd_addr_b) > addr_max) addr_max = int'(rd_addr_b);
      if (addr_prev == 19'd127 && rd_addr_b != 19'd127 && wrap_val < 0) wrap_val = int'(rd_addr_b);
      de_prev = de_b; hs_prev = hs_b; vs_prev = vs_b; addr_prev = rd_addr_b;
      tick();
    end
    check("b_fs_first", fs_cyc1, 3);
    check("b_frame_period", fs_cyc2 - fs_cyc1, 336);
    check("b_fs_count", fs_cnt, 2);
    check("b_de_count", de_cnt, 256);
    check("b_rgb_blank", blank_rgb_bad, 0);
    check("b_hs_start", hs_rise1, 21);
    check("b_hs_width", hs_fall1 - hs_rise1, 3);
    check("b_vs_start", vs_rise1 - fs_cyc1, 240);
    check("b_vs_width", vs_fall1 - vs_rise1, 48);
    check("b_addr_max", addr_max, 127);
    check("b_addr_wrap", wrap_val, 0);

    // ---------------- dut_b: reset in the middle of a frame ----------------
    rst_b = 1'b1;
    tick();
    tick();
    rst_b = 1'b0;
    for (int n = 0; n < 78; n++) tick();
    check("b_mid_de", de_b, 1'b1);
    check("b_mid_addr", rd_addr_b, 19'd54);
    rst_b = 1'b1;
    tick();
    check("b_mrst_de", de_b, 1'b0);
    check("b_mrst_rgb", {r_b, g_b, b_b}, 12'h000);
    check("b_mrst_fs", fs_b, 1'b0);
    check("b_mrst_hs", hs_b, 1'b1);
    check("b_mrst_vs", vs_b, 1'b1);
    check("b_mrst_addr", rd_addr_b, 19'd0);
    rst_b = 1'b0;
    check("b_restart_addr0", rd_addr_b, 19'd0);
    tick();
    check("b_restart_addr1", rd_addr_b, 19'd1);
    check("b_restart_de1", de_b, 1'b0);
    tick();
    check("b_restart_de2", de_b, 1'b0);
    tick();
    check("b_restart_de3", de_b, 1'b1);
    check("b_restart_fs3", fs_b, 1'b1);
    check("b_restart_rgb3", {r_b, g_b, b_b}, 12'h000);
    tick();
    check("b_restart_rgb4", {r_b, g_b, b_b}, 12'h001);
    check("b_restart_fs4", fs_b, 1'b0);

`ifdef VGA_TEST_PATTERN_EN
    // ---------------- dut_a: colour bars ----------------
    rst_b = 1'b1;
    rst_a = 1'b1;
    tick();
    tick();
    pat_en_a = 1'b1;
    rst_a = 1'b0;
    for (int n = 0; n <= 310; n++) begin
      if (n == 2)   check("p_x0",   {r_a, g_a, b_a}, 12'hFFF);
      if (n == 101) check("p_x99",  {r_a, g_a, b_a}, 12'hFFF);
      if (n == 102) check("p_x100", {r_a, g_a, b_a}, 12'hFF0);
      if (n == 202) check("p_x200", {r_a, g_a, b_a}, 12'h0FF);
      if (n == 300) pat_en_a = 1'b0;
      if (n == 305) check("p_off_x303", {r_a, g_a, b_a}, 12'h12F);
      if (n == 305) check("p_off_de", de_a, 1'b1);
      tick();
    end
    rst_a = 1'b1;
    tick();
    pat_en_a = 1'b1;
    rst_a = 1'b0;
    for (int n = 0; n <= 802; n++) begin
      if (n == 601) check("p_x599", {r_a, g_a, b_a}, 12'hF00);
      if (n == 702) check("p_x700", {r_a, g_a, b_a}, 12'h000);
      if (n == 702) check("p_x700_de", de_a, 1'b1);
      if (n == 801) check("p_x799", {r_a, g_a, b_a}, 12'h000);
      if (n == 802) check("p_blank_de", de_a, 1'b0);
      tick();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
